// File: rtl/dma_rq_tag_scheduler.sv
// Splits one host-read descriptor into 4 KB-safe memory-read requests and
// tracks a completion tag per request. Optional tag timeout: DMA_TAG_TIMEOUT_EN.
module dma_rq_tag_scheduler #(
   parameter int unsigned C_WINDOW_SIZE           = 16,
   parameter int unsigned C_LOG2_MAX_READ_REQUEST = 9,
   parameter int unsigned C_TIMEOUT_CYCLES        = 65535
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic                        DESC_TVALID,
   output logic                        DESC_TREADY,
   input  logic [63:0]                 DESC_ADDR,
   input  logic [20:0]                 DESC_BYTES,
   output logic                        DESC_DONE,
   output logic                        RQ_VALID,
   input  logic                        RQ_READY,
   output logic [63:0]                 RQ_ADDR,
   output logic [10:0]                 RQ_DWORDS,
   output logic [7:0]                  RQ_TAG,
   input  logic [63:0]                 CURRENT_WINDOW_SIZE,
   input  logic [C_WINDOW_SIZE-1:0]    COMPLETED_TAGS,
   output logic [C_WINDOW_SIZE-1:0]    BUSY_TAGS,
   output logic [C_WINDOW_SIZE*11-1:0] SIZE_TAGS,
   output logic [7:0]                  OUTSTANDING,
   output logic [C_WINDOW_SIZE-1:0]    TIMEOUT_TAGS
);

   if (C_WINDOW_SIZE < 1 || C_WINDOW_SIZE > 32 ||
       C_LOG2_MAX_READ_REQUEST < 7 || C_LOG2_MAX_READ_REQUEST > 12 ||
       C_TIMEOUT_CYCLES < 1 || C_TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("dma_rq_tag_scheduler: parameter out of range");
   end

   localparam logic [10:0] LP_MAX_DW = 11'(1 << (C_LOG2_MAX_READ_REQUEST - 2));

   typedef enum logic [1:0] {
      S_IDLE,
      S_ALLOC,
      S_ISSUE,
      S_WAIT_DRAIN
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;

   logic [63:0]                r_addr;
   logic [20:0]                r_rem;
   logic                       r_rq_valid;
   logic [63:0]                r_rq_addr;
   logic [10:0]                r_rq_dwords;
   logic [7:0]                 r_rq_tag;
   logic [C_WINDOW_SIZE-1:0]   r_busy;
   logic [10:0]                r_size [C_WINDOW_SIZE];
   logic [7:0]                 r_outstanding;
   logic                       r_done;

   logic                       w_desc_tready;
   logic                       w_desc_acc;
   logic                       w_alloc_go;
   logic                       w_issue_hs;
   logic                       w_last_chunk;
   logic                       w_drain_done;
   logic [5:0]                 w_lim;
   logic                       w_have_tag;
   logic [7:0]                 w_tag;
   logic [10:0]                w_bnd_dw;
   logic [10:0]                w_cap_dw;
   logic [18:0]                w_rem_dw;
   logic [10:0]                w_chunk_dw;
   logic [12:0]                w_rq_bytes;
   logic [C_WINDOW_SIZE-1:0]   w_set;
   logic [C_WINDOW_SIZE-1:0]   w_clr;
   logic [C_WINDOW_SIZE-1:0]   w_busy_nxt;
   logic [7:0]                 w_popcnt;

   // Window limit, with 0 treated as 1 and capped at the physical tag count
   always_comb begin
      if (CURRENT_WINDOW_SIZE == '0)
         w_lim = 6'd1;
      else if (CURRENT_WINDOW_SIZE > 64'(C_WINDOW_SIZE))
         w_lim = 6'(C_WINDOW_SIZE);
      else
         w_lim = CURRENT_WINDOW_SIZE[5:0];
   end

   always_comb begin
      w_have_tag = 1'b0;
      w_tag      = '0;
      for (int unsigned j = 0; j < C_WINDOW_SIZE; j++) begin
         if (!w_have_tag && (j < 32'(w_lim)) && !r_busy[j]) begin
            w_have_tag = 1'b1;
            w_tag      = 8'(j);
         end
      end
   end

   // Chunk sizing in dwords: remaining, max request, distance to 4 KB boundary
   always_comb begin
      w_bnd_dw   = 11'd1024 - {1'b0, r_addr[11:2]};
      w_cap_dw   = (w_bnd_dw < LP_MAX_DW) ? w_bnd_dw : LP_MAX_DW;
      w_rem_dw   = r_rem[20:2];
      w_chunk_dw = (w_rem_dw < 19'(w_cap_dw)) ? w_rem_dw[10:0] : w_cap_dw;
      w_rq_bytes = {r_rq_dwords, 2'b00};
   end

   // FSM output / control decode
   always_comb begin
      w_desc_tready = (r_state == S_IDLE);
      w_desc_acc    = w_desc_tready && DESC_TVALID;
      w_alloc_go    = (r_state == S_ALLOC) && w_have_tag;
      w_issue_hs    = (r_state == S_ISSUE) && RQ_READY;
      w_last_chunk  = (r_rem == 21'(w_rq_bytes));
      w_drain_done  = (r_state == S_WAIT_DRAIN) && (r_busy == '0);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:       if (DESC_TVALID) w_state_nxt = S_ALLOC;
         S_ALLOC:      if (w_have_tag) w_state_nxt = S_ISSUE;
         S_ISSUE:      if (RQ_READY) w_state_nxt = w_last_chunk ? S_WAIT_DRAIN : S_ALLOC;
         S_WAIT_DRAIN: if (r_busy == '0) w_state_nxt = S_IDLE;
         default:      w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      for (int unsigned j = 0; j < C_WINDOW_SIZE; j++)
         w_set[j] = w_issue_hs && (r_rq_tag == 8'(j));
   end

`ifdef DMA_TAG_TIMEOUT_EN
   localparam logic [15:0] LP_TO_LAST = 16'(C_TIMEOUT_CYCLES - 1);

   logic [15:0]              r_to_cnt [C_WINDOW_SIZE];
   logic [C_WINDOW_SIZE-1:0] r_timeout;
   logic [C_WINDOW_SIZE-1:0] w_to_fire;

   // A completion arriving on the expiry cycle wins over the timeout
   always_comb begin
      for (int unsigned j = 0; j < C_WINDOW_SIZE; j++)
         w_to_fire[j] = r_busy[j] && !COMPLETED_TAGS[j] && (r_to_cnt[j] == LP_TO_LAST);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_timeout <= '0;
         for (int unsigned j = 0; j < C_WINDOW_SIZE; j++)
            r_to_cnt[j] <= '0;
      end else begin
         r_timeout <= w_to_fire;
         for (int unsigned j = 0; j < C_WINDOW_SIZE; j++) begin
            if (w_set[j])
               r_to_cnt[j] <= '0;
            else if (r_busy[j])
               r_to_cnt[j] <= r_to_cnt[j] + 16'd1;
         end
      end
   end

   assign w_clr        = (COMPLETED_TAGS & r_busy) | w_to_fire;
   assign TIMEOUT_TAGS = r_timeout;
`else
   assign w_clr        = COMPLETED_TAGS & r_busy;
   assign TIMEOUT_TAGS = '0;
`endif

   always_comb begin
      w_busy_nxt = (r_busy & ~w_clr) | w_set;
      w_popcnt   = '0;
      for (int unsigned j = 0; j < C_WINDOW_SIZE; j++)
         w_popcnt = w_popcnt + 8'(w_busy_nxt[j]);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_addr        <= '0;
         r_rem         <= '0;
         r_rq_valid    <= 1'b0;
         r_rq_addr     <= '0;
         r_rq_dwords   <= '0;
         r_rq_tag      <= '0;
         r_busy        <= '0;
         r_outstanding <= '0;
         r_done        <= 1'b0;
         for (int unsigned j = 0; j < C_WINDOW_SIZE; j++)
            r_size[j] <= '0;
      end else begin
         r_done        <= w_drain_done;
         r_busy        <= w_busy_nxt;
         r_outstanding <= w_popcnt;
         if (w_desc_acc) begin
            r_addr <= DESC_ADDR;
            r_rem  <= (DESC_BYTES == '0) ? 21'h100000 : DESC_BYTES;
         end else if (w_issue_hs) begin
            r_addr <= r_addr + 64'(w_rq_bytes);
            r_rem  <= r_rem - 21'(w_rq_bytes);
         end
         if (w_alloc_go) begin
            r_rq_valid  <= 1'b1;
            r_rq_addr   <= r_addr;
            r_rq_dwords <= w_chunk_dw;
            r_rq_tag    <= w_tag;
         end else if (w_issue_hs) begin
            r_rq_valid  <= 1'b0;
         end
         for (int unsigned j = 0; j < C_WINDOW_SIZE; j++)
            if (w_set[j]) r_size[j] <= r_rq_dwords;
      end
   end

   for (genvar g = 0; g < C_WINDOW_SIZE; g++) begin : g_size
      assign SIZE_TAGS[11*g +: 11] = r_size[g];
   end

   assign DESC_TREADY = w_desc_tready;
   assign DESC_DONE   = r_done;
   assign RQ_VALID    = r_rq_valid;
   assign RQ_ADDR     = r_rq_addr;
   assign RQ_DWORDS   = r_rq_dwords;
   assign RQ_TAG      = r_rq_tag;
   assign BUSY_TAGS   = r_busy;
   assign OUTSTANDING = r_outstanding;

endmodule

// File: doc/dma_rq_tag_scheduler.md
Name: dma_rq_tag_scheduler

Overview:
Read-request scheduler feeding the DMA requester path.
- Accepts one host-read descriptor (address, byte length) and splits it into memory-read requests.
- Allocates a free completion tag to each request from a bounded window.
- Publishes BUSY_TAGS/SIZE_TAGS to the completion logic and frees tags on its COMPLETED_TAGS pulses.
- Signals descriptor completion when every tag it issued has been returned.

Parameters:
C_WINDOW_SIZE, 16, number of tags managed (1..32).
C_LOG2_MAX_READ_REQUEST, 9, maximum read-request size is 2**value bytes (7..12).
C_TIMEOUT_CYCLES, 65535, tag timeout in cycles; used only with the optional feature.

Ports:
CLK  in  1  clock.
RST_N  in  1  reset.
DESC_TVALID  in  1  descriptor valid.
DESC_TREADY  out  1  descriptor accepted when high with DESC_TVALID.
DESC_ADDR  in  64  host byte address; dword aligned.
DESC_BYTES  in  21  length in bytes; multiple of 4; 4..1048576, where value 0 encodes 1 MiB.
DESC_DONE  out  1  one-cycle pulse when the descriptor has fully completed.
RQ_VALID  out  1  request valid.
RQ_READY  in  1  request accepted.
RQ_ADDR  out  64  request address.
RQ_DWORDS  out  11  request length in dwords.
RQ_TAG  out  8  allocated tag, zero-extended.
CURRENT_WINDOW_SIZE  in  64  runtime limit on usable tags.
COMPLETED_TAGS  in  C_WINDOW_SIZE  per-tag completion pulses.
BUSY_TAGS  out  C_WINDOW_SIZE  tags outstanding.
SIZE_TAGS  out  C_WINDOW_SIZE*11  expected dwords per tag; tag j occupies bits 11*j+10 to 11*j.
OUTSTANDING  out  8  popcount of BUSY_TAGS, registered.
TIMEOUT_TAGS  out  C_WINDOW_SIZE  per-tag timeout pulses.

Behaviour:
- Reset: RST_N, asynchronous, active-low; clock CLK.
- Every output resets to 0 except DESC_TREADY, which resets to 1. The FSM resets to IDLE and all per-tag state is cleared.
- Window limit: lim = min(CURRENT_WINDOW_SIZE, C_WINDOW_SIZE). A value of 0 is treated as 1.
- Tag eligibility: tag j is eligible only if j < lim and BUSY_TAGS[j] = 0. The lowest eligible index wins.
- Chunk size: min(remaining, 2**C_LOG2_MAX_READ_REQUEST, 4096 - addr[11:0]). A chunk never crosses a 4 KB boundary. RQ_DWORDS = chunk/4.
- FSM states and transitions:
  - IDLE: DESC_TREADY = 1. On DESC_TVALID, capture addr and remaining (0 maps to 2**20), then go to ALLOC. DESC_TREADY is 0 in every other state.
  - ALLOC: if an eligible tag exists, register RQ_ADDR/RQ_DWORDS/RQ_TAG, set RQ_VALID = 1 the next cycle, and go to ISSUE. Otherwise stay.
  - ISSUE: RQ_VALID and all RQ fields are held stable until RQ_READY. On the handshake cycle:
    - RQ_VALID drops, BUSY_TAGS[tag] is set, and SIZE_TAGS[tag] = RQ_DWORDS; both are visible the next cycle.
    - addr += chunk and remaining -= chunk.
    - Next state is WAIT_DRAIN if remaining = 0, otherwise ALLOC.
  - WAIT_DRAIN: when BUSY_TAGS = 0, pulse DESC_DONE for 1 cycle and go to IDLE.
- Handshake latency: from handshake to the next RQ_VALID is at least 2 cycles (ALLOC then ISSUE).
- Tag release:
  - COMPLETED_TAGS[j] with BUSY_TAGS[j] = 1 clears BUSY_TAGS[j] the next cycle. SIZE_TAGS[j] retains its value until reallocation.
  - The tag is eligible in ALLOC one cycle after the clear, since eligibility uses registered BUSY_TAGS.
  - COMPLETED_TAGS[j] for a non-busy tag is ignored.
- Simultaneous set of tag a and clear of tag b (a != b) in the same cycle: both apply. Set and clear of the same tag in one cycle is impossible, because allocation excludes busy tags.
- CURRENT_WINDOW_SIZE lowered while tags are outstanding: busy tags at or above the new lim remain tracked until completed. Only allocation is restricted.
- RST_N asserted mid-descriptor: all tags are dropped, no DESC_DONE is produced, and in-flight completions after reset are ignored because BUSY_TAGS = 0.

Optional Feature:
Macro DMA_TAG_TIMEOUT_EN.
- Defined:
  - Per-tag 16-bit counter, cleared on allocation; it increments while the tag is busy.
  - When it reaches C_TIMEOUT_CYCLES, the tag is force-cleared and TIMEOUT_TAGS[j] pulses for 1 cycle.
  - A COMPLETED_TAGS pulse in the same cycle takes priority: no timeout pulse.
- Undefined: no counters, and TIMEOUT_TAGS is tied to 0.

Test Plan:
1. C_LOG2_MAX_READ_REQUEST = 8, window 16; descriptor 0x1000 / 0x400 bytes -> four requests at 0x1000, 0x1100, 0x1200, 0x1300, each 64 dwords, tags 0..3, SIZE_TAGS = 64. After COMPLETED_TAGS pulses for 0..3, DESC_DONE is high for exactly 1 cycle and DESC_TREADY returns to 1.
2. Descriptor 0x0F80 / 256 bytes -> requests 0x0F80 / 32 dwords tag 0, then 0x1000 / 32 dwords tag 1.
3. CURRENT_WINDOW_SIZE = 2, descriptor 2048 bytes at 0x0 with max 256 -> only tags 0 and 1 are issued and OUTSTANDING = 2 stalls. A pulse on COMPLETED_TAGS[0] yields the next RQ_VALID with tag 0 within 3 cycles.
4. RQ_READY held low for 5 cycles -> RQ_ADDR/RQ_DWORDS/RQ_TAG stay stable, BUSY_TAGS is unchanged, and the tag is set only after the handshake.
5. RST_N pulsed low with 3 tags busy -> all outputs are at reset values, and a subsequent COMPLETED_TAGS pulse causes no change.
6. With DMA_TAG_TIMEOUT_EN and C_TIMEOUT_CYCLES = 100, issue one request and never complete it -> TIMEOUT_TAGS[0] pulses 100 cycles after allocation, BUSY_TAGS[0] clears, then DESC_DONE pulses.
